// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants, IF/ID record type and helpers
package riscv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Contents of a pipeline register holding a bubble (addi x0,x0,0, not valid)
    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};

    // Instruction targets must be word aligned; any low address bit set is a fault
    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        if (en && cnt != 32'hFFFF_FFFF) begin
            return cnt + 32'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register with reset > flush > stall > load priority
module if_id_reg
    import riscv_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t stage_q;
    if_id_t stage_d;

    // Next contents: a flush beats a stall so a squashed slot never lingers
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = IF_ID_BUBBLE;
        end else if (!stall) begin
            stage_d = d;
        end
    end

    // Register with synchronous reset back to a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= IF_ID_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V IF stage: PC, redirect/trap, IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        fetch_fault
);

    logic [31:0] pc_f_q;
    logic [31:0] pc_f_d;
    logic        fault_q;
    logic        fault_d;
    if_id_t      if_id_in;
    if_id_t      if_id_out;

    // Next PC: redirect (trapping on a misaligned target) beats stall beats sequential step
    always_comb begin
        pc_f_d  = pc_f_q + PC_STEP;
        fault_d = fault_q;
        if (pc_src_e) begin
            if (misaligned(pc_target_e)) begin
                pc_f_d  = TRAP_PC;
                fault_d = 1'b1;
            end else begin
                pc_f_d  = pc_target_e;
            end
        end else if (stall_f) begin
            pc_f_d = pc_f_q;
        end
    end

    // PC and sticky fault flag; only reset clears the fault
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q  <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_f_q  <= pc_f_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr   = pc_f_q;
    assign fetch_fault = fault_q;

    // Record captured into IF/ID when neither flushed nor stalled
    always_comb begin
        if_id_in.instr    = imem_rdata;
        if_id_in.pc       = pc_f_q;
        if_id_in.pc_plus4 = pc_f_q + PC_STEP;
        if_id_in.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .flush (flush_d),
        .stall (stall_d),
        .d     (if_id_in),
        .q     (if_id_out)
    );

    assign instr_d    = if_id_out.instr;
    assign pc_d       = if_id_out.pc;
    assign pc_plus4_d = if_id_out.pc_plus4;
    assign valid_d    = if_id_out.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters: valid loads, PC stalls not overridden by a redirect, flushes
    always_comb begin
        fetch_cnt_d = sat_inc(fetch_cnt_q, !flush_d && !stall_d);
        stall_cnt_d = sat_inc(stall_cnt_q, stall_f && !pc_src_e);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_d);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = 32'd0;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, fetch_fault;
    logic [31:0] imem_addr_w, imem_rdata_w, instr_d_w, pc_d_w, pc_plus4_d_w;
    logic        valid_d_w, fetch_fault_w;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
    logic [31:0] perf_fetch_cnt_w, perf_stall_cnt_w, perf_flush_cnt_w;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          edge_no;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return 32'hC000_0000 | a;
    endfunction

    assign imem_rdata   = imem(imem_addr);
    assign imem_rdata_w = imem(imem_addr_w);

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .fetch_fault(fetch_fault)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .instr_d(instr_d_w), .pc_d(pc_d_w), .pc_plus4_d(pc_plus4_d_w),
        .valid_d(valid_d_w),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt_w), .perf_stall_cnt(perf_stall_cnt_w),
        .perf_flush_cnt(perf_flush_cnt_w),
`endif
        .fetch_fault(fetch_fault_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose edge has already happened
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_no == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("imem_addr@%0d", e.edge_no), imem_addr, e.addr);
            chk($sformatf("instr_d@%0d", e.edge_no), instr_d, e.instr);
            chk($sformatf("pc_d@%0d", e.edge_no), pc_d, e.pc);
            chk($sformatf("pc_plus4_d@%0d", e.edge_no), pc_plus4_d, e.pc4);
            chk($sformatf("valid_d@%0d", e.edge_no), {31'd0, valid_d}, {31'd0, e.valid});
            chk($sformatf("fetch_fault@%0d", e.edge_no), {31'd0, fetch_fault}, {31'd0, e.fault});
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt,
                        input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] p4, input logic v, input logic f);
        exp_t e;
        reset = rst; stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = ps; pc_target_e = tgt;
        e.edge_no = cyc + 1;
        e.addr = a; e.instr = i; e.pc = p; e.pc4 = p4; e.valid = v; e.fault = f;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        #1;
        //   rst sf sd fd ps target   addr      instr          pc       pc4      v  f
        step(1, 0, 0, 0, 0, 32'h0,   32'h0,   NOP,           32'h0,   32'h0,   0, 0);
        step(1, 1, 1, 0, 1, 32'h40,  32'h0,   NOP,           32'h0,   32'h0,   0, 0);
        chk("wrap_reset_addr", imem_addr_w, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 32'h0,   32'h4,   32'h0050_0093, 32'h0,   32'h4,   1, 0);
        chk("wrap_addr", imem_addr_w, 32'h0);
        chk("wrap_pc_plus4", pc_plus4_d_w, 32'h0);
        chk("wrap_fault", {31'd0, fetch_fault_w}, 32'd0);
        step(0, 0, 0, 0, 0, 32'h0,   32'h8,   32'h0010_0113, 32'h4,   32'h8,   1, 0);
        step(0, 1, 1, 0, 0, 32'h0,   32'h8,   32'h0010_0113, 32'h4,   32'h8,   1, 0);
        step(0, 1, 1, 0, 0, 32'h0,   32'h8,   32'h0010_0113, 32'h4,   32'h8,   1, 0);
        step(0, 0, 0, 0, 0, 32'h0,   32'hC,   32'hC000_0008, 32'h8,   32'hC,   1, 0);
        step(0, 0, 0, 0, 0, 32'h0,   32'h10,  32'hC000_000C, 32'hC,   32'h10,  1, 0);
        step(0, 0, 0, 1, 1, 32'h40,  32'h40,  NOP,           32'h0,   32'h0,   0, 0);
        step(0, 0, 0, 0, 0, 32'h0,   32'h44,  32'hC000_0040, 32'h40,  32'h44,  1, 0);
        step(0, 1, 1, 0, 1, 32'h80,  32'h80,  32'hC000_0040, 32'h40,  32'h44,  1, 0);
        step(0, 0, 0, 0, 0, 32'h0,   32'h84,  32'hC000_0080, 32'h80,  32'h84,  1, 0);
        step(0, 0, 1, 1, 0, 32'h0,   32'h88,  NOP,           32'h0,   32'h0,   0, 0);
        step(0, 1, 0, 0, 0, 32'h0,   32'h88,  32'hC000_0088, 32'h88,  32'h8C,  1, 0);
        step(0, 0, 0, 1, 1, 32'h42,  32'h100, NOP,           32'h0,   32'h0,   0, 1);
        step(0, 0, 0, 0, 0, 32'h0,   32'h104, 32'hC000_0100, 32'h100, 32'h104, 1, 1);
        step(0, 0, 0, 1, 1, 32'h200, 32'h200, NOP,           32'h0,   32'h0,   0, 1);
        step(0, 0, 0, 0, 0, 32'h0,   32'h204, 32'hC000_0200, 32'h200, 32'h204, 1, 1);
        step(1, 1, 1, 0, 0, 32'h0,   32'h0,   NOP,           32'h0,   32'h0,   0, 0);
        step(0, 0, 0, 0, 0, 32'h0,   32'h4,   32'h0050_0093, 32'h0,   32'h4,   1, 0);
        step(0, 1, 1, 0, 0, 32'h0,   32'h4,   32'h0050_0093, 32'h0,   32'h4,   1, 0);
        step(0, 1, 1, 0, 0, 32'h0,   32'h4,   32'h0050_0093, 32'h0,   32'h4,   1, 0);
        step(0, 1, 1, 0, 0, 32'h0,   32'h4,   32'h0050_0093, 32'h0,   32'h4,   1, 0);
        stall_f = 0; stall_d = 0;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'd1);
        chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
